tlc_sched: RTL and testbench

TLC_SCHED -- requirements
Module: tlc_sched

---
 rtl/tlc_pkg.sv | 50 +++++
 rtl/tlc_sched_if.sv | 32 +++
 rtl/tlc_req_latch.sv | 21 ++
 rtl/tlc_sched.sv | 139 +++++++++++++
 tb/tb_tlc_sched.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// Shared phase encoding, timer width, default durations and lamp decode for the traffic-light scheduler.
package tlc_pkg;

  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned TIMER_W    = 4;
  localparam int unsigned T_GMIN_DEF = 8;
  localparam int unsigned T_LEFT_DEF = 4;
  localparam int unsigned T_YEL_DEF  = 2;
  localparam int unsigned T_AR_DEF   = 2;

  typedef enum logic [PHASE_W-1:0] {
    ALLRED = 3'd0,
    HGRN   = 3'd1,
    HYEL   = 3'd2,
    HLFT   = 3'd3,
    FLFT   = 3'd4,
    FYEL   = 3'd5
  } phase_e;

  typedef enum logic {
    LAST_H = 1'b0,
    LAST_F = 1'b1
  } last_e;

  typedef struct packed {
    logic hgreen;
    logic hleft;
    logic hyellow;
    logic hred;
    logic fleft;
    logic fyellow;
    logic fred;
  } lamps_t;

  // Lamp pattern shown while a phase is active; unused codes fall back to all-red.
  function automatic lamps_t lamp_decode(phase_e p);
    lamps_t l;
    l = '0;
    case (p)
      HGRN:    begin l.hgreen  = 1'b1; l.fred = 1'b1; end
      HLFT:    begin l.hleft   = 1'b1; l.fred = 1'b1; end
      HYEL:    begin l.hyellow = 1'b1; l.fred = 1'b1; end
      FLFT:    begin l.fleft   = 1'b1; l.hred = 1'b1; end
      FYEL:    begin l.fyellow = 1'b1; l.hred = 1'b1; end
      default: begin l.hred    = 1'b1; l.fred = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_sched_if.sv
// Sensor/tick inputs and lamp/status outputs of the scheduler.
interface tlc_sched_if;

  logic                         TICK;
  logic                         HS;
  logic                         FS;
  logic                         FORCE;
  logic                         HGREEN;
  logic                         HLEFT;
  logic                         HYELLOW;
  logic                         HRED;
  logic                         FLEFT;
  logic                         FYELLOW;
  logic                         FRED;
  logic [tlc_pkg::PHASE_W-1:0]  PHASE;
  logic [tlc_pkg::TIMER_W-1:0]  REMAIN;
  logic                         HACK;
  logic                         FACK;

  modport master (
    output TICK, HS, FS, FORCE,
    input  HGREEN, HLEFT, HYELLOW, HRED, FLEFT, FYELLOW, FRED,
    input  PHASE, REMAIN, HACK, FACK
  );

  modport slave (
    input  TICK, HS, FS, FORCE,
    output HGREEN, HLEFT, HYELLOW, HRED, FLEFT, FYELLOW, FRED,
    output PHASE, REMAIN, HACK, FACK
  );

endinterface

// File: rtl/tlc_req_latch.sv
// Sticky request flag: set by sensor, clear has priority, async reset.
module tlc_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_req
);

  logic r_req;

  // Hold request until it is served; a same-cycle clear beats a set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_req <= 1'b0;
    else if (i_clr) r_req <= 1'b0;
    else if (i_set) r_req <= 1'b1;
  end

  assign o_req = r_req;

endmodule

// File: rtl/tlc_sched.sv
// Highway/farm-road traffic-light scheduler with left-turn phases, fair arbitration and preemption.
module tlc_sched
  import tlc_pkg::*;
#(
  parameter int unsigned T_GMIN = T_GMIN_DEF,
  parameter int unsigned T_LEFT = T_LEFT_DEF,
  parameter int unsigned T_YEL  = T_YEL_DEF,
  parameter int unsigned T_AR   = T_AR_DEF
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  tlc_sched_if.slave    bus
);

  phase_e               r_state, w_state_nxt;
  phase_e               r_next,  w_next_nxt;
  last_e                r_last,  w_last_nxt;
  logic [TIMER_W-1:0]   r_timer, w_timer_nxt;
  lamps_t               r_lamps;
  logic                 r_hack, r_fack;
  logic                 w_req_h, w_req_f;
  logic                 w_tmr_zero;
  logic                 w_enter_hlft, w_enter_flft;
  logic                 w_grant_h;

  // Timer reload value (duration minus one) for the phase being entered.
  function automatic logic [TIMER_W-1:0] dur_m1(phase_e p);
    case (p)
      HGRN:       return TIMER_W'(T_GMIN - 1);
      HLFT, FLFT: return TIMER_W'(T_LEFT - 1);
      HYEL, FYEL: return TIMER_W'(T_YEL - 1);
      default:    return TIMER_W'(T_AR - 1);
    endcase
  endfunction

  assign w_tmr_zero   = (r_timer == '0);
  assign w_enter_hlft = (w_state_nxt == HLFT) && (r_state != HLFT);
  assign w_enter_flft = (w_state_nxt == FLFT) && (r_state != FLFT);
  assign w_grant_h    = w_req_h && (!w_req_f || (r_last == LAST_F));

  tlc_req_latch u_req_h (
    .clk   (MCLK),
    .rst_n (RESET_N),
    .i_set (bus.HS && (r_state != HLFT)),
    .i_clr (w_enter_hlft),
    .o_req (w_req_h)
  );

  tlc_req_latch u_req_f (
    .clk   (MCLK),
    .rst_n (RESET_N),
    .i_set (bus.FS && (r_state != FLFT)),
    .i_clr (w_enter_flft),
    .o_req (w_req_f)
  );

  // Phase state, pending-next, arbitration memory and phase timer.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ALLRED;
      r_next  <= HGRN;
      r_last  <= LAST_F;
      r_timer <= TIMER_W'(T_AR - 1);
    end else begin
      r_state <= w_state_nxt;
      r_next  <= w_next_nxt;
      r_last  <= w_last_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next phase/timer: everything advances only on TICK; entering a phase reloads its timer.
  always_comb begin
    w_state_nxt = r_state;
    w_next_nxt  = r_next;
    w_last_nxt  = r_last;
    w_timer_nxt = r_timer;
    if (bus.TICK) begin
      case (r_state)
        ALLRED: if (w_tmr_zero) w_state_nxt = r_next;
        HGRN: begin
          if (w_tmr_zero && !bus.FORCE && (w_req_h || w_req_f)) begin
            w_state_nxt = HYEL;
            if (w_grant_h) begin
              w_next_nxt = HLFT;
              w_last_nxt = LAST_H;
            end else begin
              w_next_nxt = FLFT;
              w_last_nxt = LAST_F;
            end
          end
        end
        HYEL: if (w_tmr_zero) w_state_nxt = ALLRED;
        HLFT: begin
          if (w_tmr_zero || bus.FORCE) begin
            w_state_nxt = HYEL;
            w_next_nxt  = HGRN;
          end
        end
        FLFT: if (w_tmr_zero || bus.FORCE) w_state_nxt = FYEL;
        FYEL: begin
          if (w_tmr_zero) begin
            w_state_nxt = ALLRED;
            w_next_nxt  = HGRN;
          end
        end
        default: w_state_nxt = ALLRED;
      endcase
      if (w_state_nxt != r_state) w_timer_nxt = dur_m1(w_state_nxt);
      else if (!w_tmr_zero)       w_timer_nxt = r_timer - TIMER_W'(1);
    end
  end

  // Lamps and grant pulses registered alongside the phase they belong to.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_lamps <= lamp_decode(ALLRED);
      r_hack  <= 1'b0;
      r_fack  <= 1'b0;
    end else begin
      r_lamps <= lamp_decode(w_state_nxt);
      r_hack  <= w_enter_hlft;
      r_fack  <= w_enter_flft;
    end
  end

  assign bus.HGREEN  = r_lamps.hgreen;
  assign bus.HLEFT   = r_lamps.hleft;
  assign bus.HYELLOW = r_lamps.hyellow;
  assign bus.HRED    = r_lamps.hred;
  assign bus.FLEFT   = r_lamps.fleft;
  assign bus.FYELLOW = r_lamps.fyellow;
  assign bus.FRED    = r_lamps.fred;
  assign bus.PHASE   = r_state;
  assign bus.REMAIN  = r_timer;
  assign bus.HACK    = r_hack;
  assign bus.FACK    = r_fack;

endmodule

// File: tb/tb_tlc_sched.sv
// Bench for tlc_sched: scripted tick table, corner-case sequences and randomized run against a phase model.
module tb_tlc_sched;
  import tlc_pkg::*;

  localparam int T_GMIN = 8;
  localparam int T_LEFT = 4;
  localparam int T_YEL  = 2;
  localparam int T_AR   = 2;

  localparam logic [6:0] L_HG = 7'b1000001;
  localparam logic [6:0] L_HL = 7'b0100001;
  localparam logic [6:0] L_HY = 7'b0010001;
  localparam logic [6:0] L_AR = 7'b0001001;
  localparam logic [6:0] L_FL = 7'b0001100;
  localparam logic [6:0] L_FY = 7'b0001010;

  logic MCLK;
  logic RESET_N;
  tlc_sched_if bus();

  tlc_sched #(.T_GMIN(T_GMIN), .T_LEFT(T_LEFT), .T_YEL(T_YEL), .T_AR(T_AR)) dut (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int n_chk = 0;
  int n_err = 0;
  int n_hack, n_fack;
  bit hs_hold = 0;
  bit mon_en  = 0;

  wire [6:0] w_lamps = {bus.HGREEN, bus.HLEFT, bus.HYELLOW, bus.HRED, bus.FLEFT, bus.FYELLOW, bus.FRED};
  wire [15:0] w_obs  = {2'b00, bus.PHASE, bus.REMAIN, w_lamps};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: phase + ticks elapsed in it ----------------
  phase_e m_ph, m_next;
  int     m_el;
  bit     m_rh, m_rf, m_lastf, m_hack, m_fack;

  function automatic int dur(phase_e p);
    case (p)
      ALLRED:     return T_AR;
      HGRN:       return T_GMIN;
      HLFT, FLFT: return T_LEFT;
      default:    return T_YEL;
    endcase
  endfunction

  function automatic logic [6:0] lamps_of(phase_e p);
    case (p)
      HGRN:    return L_HG;
      HLFT:    return L_HL;
      HYEL:    return L_HY;
      FLFT:    return L_FL;
      FYEL:    return L_FY;
      default: return L_AR;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = ALLRED; m_next = HGRN; m_el = 0;
    m_rh = 0; m_rf = 0; m_lastf = 1; m_hack = 0; m_fack = 0;
  endtask

  task automatic model_clk(input bit tick, input bit hs, input bit fs, input bit frc);
    phase_e np;
    bit     done, pick_h;
    np     = m_ph;
    pick_h = 0;
    done   = (m_el >= dur(m_ph) - 1);
    if (tick) begin
      case (m_ph)
        HGRN: if (done && !frc && (m_rh || m_rf)) begin
          pick_h  = (m_rh && m_rf) ? m_lastf : m_rh;
          np      = HYEL;
          m_next  = pick_h ? HLFT : FLFT;
          m_lastf = !pick_h;
        end
        HLFT: if (done || frc) begin np = HYEL; m_next = HGRN; end
        FLFT: if (done || frc) np = FYEL;
        HYEL: if (done) np = ALLRED;
        FYEL: if (done) begin np = ALLRED; m_next = HGRN; end
        default: if (done) np = m_next;
      endcase
    end
    m_hack = (np == HLFT) && (m_ph != HLFT);
    m_fack = (np == FLFT) && (m_ph != FLFT);
    if (hs && m_ph != HLFT) m_rh = 1;
    if (m_hack) m_rh = 0;
    if (fs && m_ph != FLFT) m_rf = 1;
    if (m_fack) m_rf = 0;
    if (np != m_ph)         m_el = 0;
    else if (tick && !done) m_el++;
    m_ph = np;
  endtask

  function automatic logic [15:0] model_obs();
    int rem;
    rem = dur(m_ph) - 1 - m_el;
    return {2'b00, 3'(m_ph), 4'(rem), lamps_of(m_ph)};
  endfunction

  initial model_reset();
  always @(negedge RESET_N) model_reset();
  always @(posedge MCLK) begin
    if (!RESET_N) model_reset();
    else          model_clk(bus.TICK, bus.HS, bus.FS, bus.FORCE);
  end

  // Compare every cycle on the falling edge, clear of the active edge.
  always @(negedge MCLK) begin
    if (mon_en) begin
      check("model_obs", w_obs, model_obs());
      check("model_ack", {14'd0, bus.HACK, bus.FACK}, {14'd0, m_hack, m_fack});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clk1(input bit tick);
    bus.TICK = tick;
    @(posedge MCLK);
    #1;
    bus.TICK = 1'b0;
    bus.HS   = hs_hold;
    bus.FS   = 1'b0;
    if (bus.HACK) n_hack++;
    if (bus.FACK) n_fack++;
  endtask

  task automatic ticks(input int n);
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < 4; k++) clk1(k == 3);
    end
  endtask

  task automatic expect_ph(input string name, input phase_e p, input int rem);
    check(name, w_obs, {2'b00, 3'(p), 4'(rem), lamps_of(p)});
  endtask

  typedef struct {
    int          n;
    bit          frc;
    bit          hs;
    bit          fs;
    phase_e      ph;
    int          rem;
    logic [6:0]  lamps;
    int          hk;
    int          fk;
  } vec_t;

  function automatic vec_t mk(input int n, input bit frc, input bit hs, input bit fs,
                              input phase_e ph, input int rem, input logic [6:0] lamps,
                              input int hk, input int fk);
    vec_t v;
    v.n = n; v.frc = frc; v.hs = hs; v.fs = fs; v.ph = ph; v.rem = rem;
    v.lamps = lamps; v.hk = hk; v.fk = fk;
    return v;
  endfunction

  vec_t tbl[23];

  initial begin
    tbl[0]  = mk( 0, 0, 0, 0, ALLRED, 1, L_AR, 0, 0);
    tbl[1]  = mk( 1, 0, 0, 0, ALLRED, 0, L_AR, 0, 0);
    tbl[2]  = mk( 1, 0, 0, 0, HGRN,   7, L_HG, 0, 0);
    tbl[3]  = mk( 2, 0, 0, 0, HGRN,   5, L_HG, 0, 0);
    tbl[4]  = mk( 5, 0, 0, 1, HGRN,   0, L_HG, 0, 0);
    tbl[5]  = mk( 1, 0, 0, 0, HYEL,   1, L_HY, 0, 0);
    tbl[6]  = mk( 2, 0, 0, 0, ALLRED, 1, L_AR, 0, 0);
    tbl[7]  = mk( 2, 0, 0, 0, FLFT,   3, L_FL, 0, 1);
    tbl[8]  = mk( 4, 0, 0, 0, FYEL,   1, L_FY, 0, 0);
    tbl[9]  = mk( 2, 0, 0, 0, ALLRED, 1, L_AR, 0, 0);
    tbl[10] = mk( 2, 0, 0, 0, HGRN,   7, L_HG, 0, 0);
    tbl[11] = mk(10, 0, 0, 0, HGRN,   0, L_HG, 0, 0);
    tbl[12] = mk( 1, 0, 1, 1, HYEL,   1, L_HY, 0, 0);
    tbl[13] = mk( 4, 0, 0, 0, HLFT,   3, L_HL, 1, 0);
    tbl[14] = mk( 4, 0, 0, 0, HYEL,   1, L_HY, 0, 0);
    tbl[15] = mk( 4, 0, 0, 0, HGRN,   7, L_HG, 0, 0);
    tbl[16] = mk( 8, 0, 0, 0, HYEL,   1, L_HY, 0, 0);
    tbl[17] = mk( 4, 0, 0, 0, FLFT,   3, L_FL, 0, 1);
    tbl[18] = mk( 1, 0, 0, 0, FLFT,   2, L_FL, 0, 0);
    tbl[19] = mk( 1, 1, 0, 0, FYEL,   1, L_FY, 0, 0);
    tbl[20] = mk( 4, 1, 1, 0, HGRN,   7, L_HG, 0, 0);
    tbl[21] = mk(10, 1, 0, 0, HGRN,   0, L_HG, 0, 0);
    tbl[22] = mk( 1, 0, 0, 0, HYEL,   1, L_HY, 0, 0);

    bus.TICK = 0; bus.HS = 0; bus.FS = 0; bus.FORCE = 0;
    RESET_N = 1'b0;
    @(posedge MCLK);
    #2 mon_en = 1;
    @(posedge MCLK);
    #1 RESET_N = 1'b1;

    // Scripted tick table: one TICK every 4 MCLK.
    for (int i = 0; i < 23; i++) begin
      n_hack = 0; n_fack = 0;
      bus.FORCE = tbl[i].frc;
      bus.HS    = tbl[i].hs;
      bus.FS    = tbl[i].fs;
      ticks(tbl[i].n);
      bus.HS = hs_hold; bus.FS = 0;
      check($sformatf("row%0d", i), w_obs, {2'b00, 3'(tbl[i].ph), 4'(tbl[i].rem), tbl[i].lamps});
      check($sformatf("row%0d_acks", i), {8'(n_hack), 8'(n_fack)}, {8'(tbl[i].hk), 8'(tbl[i].fk)});
    end
    bus.FORCE = 0;

    // HS held high through a left-turn phase relatches only after exit.
    hs_hold = 1; bus.HS = 1;
    ticks(4);  expect_ph("hs_hold_hlft", HLFT, 3);
    ticks(4);  expect_ph("hs_hold_exit", HYEL, 1);
    clk1(0);
    hs_hold = 0; bus.HS = 0;
    ticks(12); expect_ph("hs_regrant", HYEL, 1);
    ticks(4);  expect_ph("hs_regrant_hlft", HLFT, 3);

    // Async reset in the middle of a farm left-turn phase.
    bus.FS = 1; clk1(0);
    ticks(4);  expect_ph("to_hyel", HYEL, 1);
    ticks(4);  expect_ph("to_hgrn", HGRN, 7);
    ticks(8);  expect_ph("f_grant", HYEL, 1);
    ticks(4);  expect_ph("f_lft", FLFT, 3);
    ticks(1);  expect_ph("f_lft_mid", FLFT, 2);
    #2 RESET_N = 1'b0;
    #1 expect_ph("async_reset", ALLRED, T_AR - 1);
    check("async_reset_ack", {14'd0, bus.HACK, bus.FACK}, 16'd0);
    @(posedge MCLK);
    #1 RESET_N = 1'b1;
    ticks(2);  expect_ph("post_reset_hgrn", HGRN, 7);
    ticks(9);  expect_ph("req_lost", HGRN, 0);

    // Randomized stimulus, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      bus.HS    = ($urandom_range(0, 9) == 0);
      bus.FS    = ($urandom_range(0, 9) == 0);
      bus.FORCE = ($urandom_range(0, 7) == 0);
      bus.TICK  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 RESET_N = 1'b0;
        @(posedge MCLK);
        #1 RESET_N = 1'b1;
      end else begin
        @(posedge MCLK);
        #1;
      end
    end

    @(negedge MCLK);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
